// File: rtl/regfile_exec_sequencer.sv
// Multi-cycle execute sequencer for an 8-entry register file: read, execute, write back.
// Optional REGFILE_EXEC_SEQ_MUL_EN turns opcode 111 from NOP into an iterative unsigned MUL.
module regfile_exec_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       op,
  input  logic [2:0]       rd,
  input  logic [2:0]       rs1,
  input  logic [2:0]       rs2,
  input  logic [WIDTH-1:0] imm,
  output logic [2:0]       ra1,
  output logic [2:0]       ra2,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  output logic             we3,
  output logic [2:0]       wa3,
  output logic [WIDTH-1:0] wd3,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             carry
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SLTU = 3'd5;
  localparam logic [2:0] OP_LI   = 3'd6;

`ifdef REGFILE_EXEC_SEQ_MUL_EN
  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned PW = 2 * WIDTH;
  typedef enum logic [2:0] {IDLE, READ, EXEC, WB, MUL} state_t;
`else
  typedef enum logic [2:0] {IDLE, READ, EXEC, WB} state_t;
`endif

  state_t           state_q, state_d;
  logic             instr_ready_q, instr_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             we3_q, we3_d;
  logic [2:0]       ra1_q, ra1_d;
  logic [2:0]       ra2_q, ra2_d;
  logic [2:0]       wa3_q, wa3_d;
  logic [WIDTH-1:0] wd3_q, wd3_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
`ifdef REGFILE_EXEC_SEQ_MUL_EN
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    acc_next;
`endif

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             upd_flags;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      instr_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      we3_q         <= 1'b0;
      ra1_q         <= '0;
      ra2_q         <= '0;
      wa3_q         <= '0;
      wd3_q         <= '0;
      zero_q        <= 1'b0;
      carry_q       <= 1'b0;
      op_q          <= '0;
      imm_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
`ifdef REGFILE_EXEC_SEQ_MUL_EN
      acc_q         <= '0;
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      instr_ready_q <= instr_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      we3_q         <= we3_d;
      ra1_q         <= ra1_d;
      ra2_q         <= ra2_d;
      wa3_q         <= wa3_d;
      wd3_q         <= wd3_d;
      zero_q        <= zero_d;
      carry_q       <= carry_d;
      op_q          <= op_d;
      imm_q         <= imm_d;
      a_q           <= a_d;
      b_q           <= b_d;
`ifdef REGFILE_EXEC_SEQ_MUL_EN
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
`endif
    end
  end

  // ALU on the captured operands; flags follow the WIDTH+1 bit intermediate
  always_comb begin
    sum       = {1'b0, a_q} + {1'b0, b_q};
    diff      = {1'b0, a_q} - {1'b0, b_q};
    alu_res   = sum[WIDTH-1:0];
    alu_carry = 1'b0;
    upd_flags = 1'b1;
    case (op_q)
      OP_ADD:  begin alu_res = sum[WIDTH-1:0];  alu_carry = sum[WIDTH];  end
      OP_SUB:  begin alu_res = diff[WIDTH-1:0]; alu_carry = diff[WIDTH]; end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SLTU: alu_res = WIDTH'(a_q < b_q);
      OP_LI:   begin alu_res = imm_q; upd_flags = 1'b0; end
      default: upd_flags = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    we3_d   = 1'b0;
    ra1_d   = ra1_q;
    ra2_d   = ra2_q;
    wa3_d   = wa3_q;
    wd3_d   = wd3_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    op_d    = op_q;
    imm_d   = imm_q;
    a_d     = a_q;
    b_d     = b_q;
`ifdef REGFILE_EXEC_SEQ_MUL_EN
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_next = acc_q + (b_q[0] ? (PW'(a_q) << cnt_q) : '0);
`endif

    case (state_q)
      IDLE: begin
        if (instr_valid && instr_ready_q) begin
          op_d    = op;
          imm_d   = imm;
          ra1_d   = rs1;
          ra2_d   = rs2;
          wa3_d   = rd;
          state_d = READ;
        end
      end
      READ: begin
        a_d     = rd1;
        b_d     = rd2;
        state_d = EXEC;
      end
      EXEC: begin
        if (op_q == 3'd7) begin
`ifdef REGFILE_EXEC_SEQ_MUL_EN
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL;
`else
          done_d  = 1'b1;
          state_d = IDLE;
`endif
        end else begin
          wd3_d   = alu_res;
          we3_d   = 1'b1;
          done_d  = 1'b1;
          state_d = WB;
          if (upd_flags) begin
            zero_d  = (alu_res == '0);
            carry_d = alu_carry;
          end
        end
      end
      WB: begin
        state_d = IDLE;
      end
`ifdef REGFILE_EXEC_SEQ_MUL_EN
      // One multiplier bit per cycle; the last iteration commits straight to WB
      MUL: begin
        acc_d = acc_next;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          wd3_d   = acc_next[WIDTH-1:0];
          zero_d  = (acc_next[WIDTH-1:0] == '0);
          carry_d = |acc_next[PW-1:WIDTH];
          we3_d   = 1'b1;
          done_d  = 1'b1;
          state_d = WB;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    instr_ready_d = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
  end

  assign instr_ready = instr_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign we3         = we3_q;
  assign ra1         = ra1_q;
  assign ra2         = ra2_q;
  assign wa3         = wa3_q;
  assign wd3         = wd3_q;
  assign zero        = zero_q;
  assign carry       = carry_q;

endmodule
